// File: rtl/pipe_stim_tracker.sv
// pipe_stim_tracker: shared input ring with per-channel read pointers, framing pipeline outputs into records
module pipe_stim_tracker #(
  parameter int PORTS    = 4,
  parameter int DATA_W   = 32,
  parameter int DII      = 11,
  parameter int CHANNELS = 7,
  parameter int OUT_W    = 64,
  parameter int DEPTH    = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic [PORTS*DATA_W-1:0]   in_data,
  input  logic [CHANNELS-1:0]       chan_mask,
  input  logic [CHANNELS-1:0]       out_valid,
  input  logic [CHANNELS*OUT_W-1:0] out_data,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic [PORTS*DATA_W-1:0]   m_data,
  output logic                      m_last,
  input  logic                      clear,
  output logic                      ovf,
  output logic                      uflow,
  output logic                      drop,
  output logic [$clog2(DEPTH):0]    occupancy
);
  localparam int W  = PORTS*DATA_W;
  localparam int AW = $clog2(DEPTH);
  localparam int BW = DII > 1 ? $clog2(DII) : 1;
  localparam int CW = CHANNELS > 1 ? $clog2(CHANNELS) : 1;
  localparam logic [1:0] IDLE = 2'd0, HDR = 2'd1, BEAT = 2'd2, OUT = 2'd3;

  logic [W-1:0]        ring_q [DEPTH][DII];
  logic [BW-1:0]       beat_q, k_q;
  logic [AW:0]         wg_q, wg_d;
  logic [AW:0]         rg_q [CHANNELS];
  logic [CHANNELS-1:0] hv_q, cap, drp, ufl;
  logic [OUT_W-1:0]    hw_q [CHANNELS];
  logic [31:0]         ht_q [CHANNELS];
  logic [15:0]         seq_q [CHANNELS];
  logic [31:0]         ts_q;
  logic [1:0]          st_q;
  logic [CW-1:0]       ch_q, prio_q, gnt;
  logic [CW:0]         j;
  logic                any_v, full, wr, done;
  logic                ovf_q, uflow_q, drop_q;

  assign full    = occupancy == (AW+1)'(DEPTH);
  assign wr      = en && !full;
  assign wg_d    = wr && beat_q == BW'(DII-1) ? wg_q + 1'b1 : wg_q;
  assign m_valid = st_q != IDLE;
  assign m_last  = st_q == OUT;
  assign done    = st_q == OUT && m_ready;
  assign ovf     = ovf_q;
  assign uflow   = uflow_q;
  assign drop    = drop_q;

  // occupancy is the distance from the write pointer to the laggiest active reader
  always_comb begin
    occupancy = '0;
    for (int n = 0; n < CHANNELS; n++)
      if (chan_mask[n] && (AW+1)'(wg_q - rg_q[n]) > occupancy) occupancy = wg_q - rg_q[n];
  end

  // classify each channel's output event as capture, drop (hold busy) or underflow (no complete group)
  always_comb begin
    cap = '0;
    drp = '0;
    ufl = '0;
    for (int n = 0; n < CHANNELS; n++) begin
      drp[n] = out_valid[n] && chan_mask[n] && hv_q[n];
      ufl[n] = out_valid[n] && chan_mask[n] && !hv_q[n] && rg_q[n] == wg_q;
      cap[n] = out_valid[n] && chan_mask[n] && !hv_q[n] && rg_q[n] != wg_q;
    end
  end

  // round-robin search for a full hold register starting at the priority pointer
  always_comb begin
    gnt   = prio_q;
    any_v = 1'b0;
    j     = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      j = {1'b0, prio_q} + (CW+1)'(i);
      j = j >= (CW+1)'(CHANNELS) ? j - (CW+1)'(CHANNELS) : j;
      if (!any_v && hv_q[j[CW-1:0]]) begin
        any_v = 1'b1;
        gnt   = j[CW-1:0];
      end
    end
  end

  // record beat selection: header, ring beats of the bound group, then the output word
  always_comb begin
    m_data = '0;
    if (st_q == HDR) begin
      m_data[55:48] = 8'(ch_q);
      m_data[47:32] = seq_q[ch_q];
      m_data[31:0]  = ht_q[ch_q];
    end else if (st_q == BEAT) m_data = ring_q[rg_q[ch_q][AW-1:0]][k_q];
    else if (st_q == OUT) m_data[OUT_W-1:0] = hw_q[ch_q];
  end

  // ring storage needs no reset: pointers decide what is valid
  always_ff @(posedge clk)
    if (wr) ring_q[wg_q[AW-1:0]][beat_q] <= in_data;

  // write side, timestamp and sticky flags (a new event beats a simultaneous clear)
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      beat_q  <= '0;
      wg_q    <= '0;
      ts_q    <= '0;
      ovf_q   <= 1'b0;
      uflow_q <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      ts_q    <= ts_q + 1'b1;
      if (wr) beat_q <= beat_q == BW'(DII-1) ? '0 : beat_q + 1'b1;
      wg_q    <= wg_d;
      ovf_q   <= (ovf_q && !clear) || (en && full);
      uflow_q <= (uflow_q && !clear) || |ufl;
      drop_q  <= (drop_q && !clear) || |drp;
    end

  // per-channel read pointer, hold register and sequence number
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      hv_q <= '0;
      for (int n = 0; n < CHANNELS; n++) begin
        rg_q[n]  <= '0;
        hw_q[n]  <= '0;
        ht_q[n]  <= '0;
        seq_q[n] <= '0;
      end
    end else begin
      for (int n = 0; n < CHANNELS; n++) begin
        if (!chan_mask[n]) rg_q[n] <= wg_d;
        else if (done && ch_q == CW'(n)) rg_q[n] <= rg_q[n] + 1'b1;
        if (done && ch_q == CW'(n)) begin
          seq_q[n] <= seq_q[n] + 1'b1;
          hv_q[n]  <= 1'b0;
        end else if (cap[n]) begin
          hv_q[n] <= 1'b1;
          hw_q[n] <= out_data[n*OUT_W +: OUT_W];
          ht_q[n] <= ts_q;
        end
      end
    end

  // emitter FSM: every framed state advances only on a handshake
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      st_q   <= IDLE;
      ch_q   <= '0;
      prio_q <= '0;
      k_q    <= '0;
    end else begin
      case (st_q)
        IDLE: if (any_v) begin
          ch_q   <= gnt;
          prio_q <= gnt == CW'(CHANNELS-1) ? '0 : gnt + 1'b1;
          st_q   <= HDR;
        end
        HDR: if (m_ready) begin
          st_q <= BEAT;
          k_q  <= '0;
        end
        BEAT: if (m_ready) begin
          if (k_q == BW'(DII-1)) st_q <= OUT;
          else k_q <= k_q + 1'b1;
        end
        OUT: if (m_ready) st_q <= IDLE;
        default: st_q <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_pipe_stim_tracker.sv
// tb_pipe_stim_tracker: scoreboard bench for the stimulus tracker (ring depth 4)
module tb_pipe_stim_tracker;
  localparam int P = 4, DW = 32, DII = 11, C = 7, OW = 64, D = 4, W = P*DW;

  typedef struct packed {logic last; logic [W-1:0] data; logic [31:0] t;} beat_t;

  logic            clk = 0, rst_n = 1, en = 0, m_ready = 1, clear = 0;
  logic [W-1:0]    in_data = '0;
  logic [C-1:0]    chan_mask = '1, out_valid = '0;
  logic [C*OW-1:0] out_data = '0;
  logic            m_valid, m_last, ovf, uflow, drop;
  logic [W-1:0]    m_data;
  logic [2:0]      occupancy;
  logic [31:0]     tsc = 0;
  logic [15:0]     seq_m [C];
  beat_t           obs[$], exp[$];
  int              checks = 0, passed = 0;

  pipe_stim_tracker #(.PORTS(P), .DATA_W(DW), .DII(DII), .CHANNELS(C), .OUT_W(OW), .DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .in_data(in_data), .chan_mask(chan_mask),
    .out_valid(out_valid), .out_data(out_data), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .m_last(m_last), .clear(clear), .ovf(ovf), .uflow(uflow),
    .drop(drop), .occupancy(occupancy));

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n)
    if (!rst_n) tsc <= 0;
    else tsc <= tsc + 1;

  always @(negedge clk)
    if (rst_n && m_valid && m_ready) obs.push_back('{m_last, m_data, tsc});

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic logic [W-1:0] beat_of(int g, int k);
    logic [W-1:0] b;
    for (int p = 0; p < P; p++) b[p*DW +: DW] = 32'(g*64 + 4*k + p);
    return b;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send_group(int g);
    for (int k = 0; k < DII; k++) begin
      en = 1;
      in_data = beat_of(g, k);
      tick;
    end
    en = 0;
  endtask

  task automatic fire(int ch, logic [OW-1:0] w, output logic [31:0] t);
    out_valid = '0;
    out_valid[ch] = 1;
    out_data[ch*OW +: OW] = w;
    t = tsc;
    tick;
    out_valid = '0;
  endtask

  task automatic expect_rec(int ch, int g, logic [OW-1:0] w, logic [31:0] t);
    logic [W-1:0] h;
    h = '0;
    h[55:48] = 8'(ch);
    h[47:32] = seq_m[ch];
    h[31:0] = t;
    exp.push_back('{1'b0, h, 32'd0});
    for (int k = 0; k < DII; k++) exp.push_back('{1'b0, beat_of(g, k), 32'd0});
    h = '0;
    h[OW-1:0] = w;
    exp.push_back('{1'b1, h, 32'd0});
    seq_m[ch]++;
  endtask

  task automatic wait_obs(int n);
    for (int i = 0; i < 600 && obs.size() < n; i++) tick;
  endtask

  task automatic do_reset;
    @(negedge clk);
    rst_n = 0;
    #2;
    rst_n = 1;
    tick;
    obs.delete();
    exp.delete();
    for (int n = 0; n < C; n++) seq_m[n] = 0;
  endtask

  task automatic test_reset;
    for (int n = 0; n < C; n++) seq_m[n] = 0;
    #2 rst_n = 0;
    #10;
    checks++;
    if ({m_valid, m_last, ovf, uflow, drop} !== 5'b0) $display("FAIL reset_ctl: got %b want 00000", {m_valid, m_last, ovf, uflow, drop});
    else passed++;
    checks++;
    if (m_data !== '0) $display("FAIL reset_data: got %h want 0", m_data);
    else passed++;
    checks++;
    if (occupancy !== 3'd0) $display("FAIL reset_occ: got %0d want 0", occupancy);
    else passed++;
    @(negedge clk);
    rst_n = 1;
    tick;
  endtask

  task automatic test_basic;
    logic [31:0] t;
    beat_t e, o;
    chan_mask = '1;
    m_ready = 1;
    send_group(0);
    fire(0, 64'hDEAD, t);
    expect_rec(0, 0, 64'hDEAD, t);
    checks++;
    if (m_valid !== 1'b0) $display("FAIL basic_idle: m_valid got %b want 0", m_valid);
    else passed++;
    tick;
    checks++;
    if (m_valid !== 1'b1 || m_data !== exp[0].data) $display("FAIL basic_latency: got %b/%h want 1/%h", m_valid, m_data, exp[0].data);
    else passed++;
    wait_obs(13);
    tick;
    while (exp.size() > 0) begin
      e = exp.pop_front();
      checks++;
      if (obs.size() == 0) $display("FAIL basic_beat: got nothing want %b/%h", e.last, e.data);
      else begin
        o = obs.pop_front();
        if ({o.last, o.data} !== {e.last, e.data}) $display("FAIL basic_beat: got %b/%h want %b/%h", o.last, o.data, e.last, e.data);
        else passed++;
      end
    end
    checks++;
    if (occupancy !== 3'd1) $display("FAIL basic_occ: got %0d want 1", occupancy);
    else passed++;
  endtask

  task automatic test_simultaneous;
    logic [31:0] t;
    beat_t e, o;
    chan_mask = 7'h24;
    tick;
    checks++;
    if (occupancy !== 3'd1) $display("FAIL simul_occ_before: got %0d want 1", occupancy);
    else passed++;
    out_valid = 7'h24;
    out_data[2*OW +: OW] = 64'hA2;
    out_data[5*OW +: OW] = 64'hA5;
    t = tsc;
    tick;
    out_valid = '0;
    expect_rec(2, 0, 64'hA2, t);
    expect_rec(5, 0, 64'hA5, t);
    wait_obs(26);
    tick;
    checks++;
    if (obs.size() < 14) $display("FAIL simul_gap: got %0d beats want 26", obs.size());
    else if (obs[13].t - obs[0].t !== 32'd14) $display("FAIL simul_gap: got %0d cycles want 14", obs[13].t - obs[0].t);
    else passed++;
    while (exp.size() > 0) begin
      e = exp.pop_front();
      checks++;
      if (obs.size() == 0) $display("FAIL simul_beat: got nothing want %b/%h", e.last, e.data);
      else begin
        o = obs.pop_front();
        if ({o.last, o.data} !== {e.last, e.data}) $display("FAIL simul_beat: got %b/%h want %b/%h", o.last, o.data, e.last, e.data);
        else passed++;
      end
    end
    checks++;
    if (occupancy !== 3'd0) $display("FAIL simul_occ_after: got %0d want 0", occupancy);
    else passed++;
  endtask

  task automatic test_backpressure;
    logic [31:0] t;
    logic [W-1:0] pd;
    logic pl, prev_stall;
    int stall_err;
    beat_t e, o;
    chan_mask = 7'h01;
    tick;
    send_group(1);
    fire(0, 64'h1234_5678_9ABC_DEF0, t);
    expect_rec(0, 1, 64'h1234_5678_9ABC_DEF0, t);
    prev_stall = 0;
    stall_err = 0;
    pd = '0;
    pl = 0;
    for (int i = 0; i < 400 && obs.size() < 13; i++) begin
      if (prev_stall && (m_valid !== 1'b1 || m_data !== pd || m_last !== pl)) stall_err++;
      m_ready = 1'($urandom_range(0, 1));
      prev_stall = m_valid && !m_ready;
      pd = m_data;
      pl = m_last;
      tick;
    end
    m_ready = 1;
    tick;
    tick;
    checks++;
    if (stall_err !== 0) $display("FAIL bp_stable: got %0d changes while stalled want 0", stall_err);
    else passed++;
    while (exp.size() > 0) begin
      e = exp.pop_front();
      checks++;
      if (obs.size() == 0) $display("FAIL bp_beat: got nothing want %b/%h", e.last, e.data);
      else begin
        o = obs.pop_front();
        if ({o.last, o.data} !== {e.last, e.data}) $display("FAIL bp_beat: got %b/%h want %b/%h", o.last, o.data, e.last, e.data);
        else passed++;
      end
    end
    checks++;
    if (obs.size() != 0) $display("FAIL bp_count: got %0d extra beats want 0", obs.size());
    else passed++;
  endtask

  task automatic test_overflow;
    logic [31:0] t;
    beat_t e, o;
    for (int g = 2; g < 6; g++) send_group(g);
    checks++;
    if (occupancy !== 3'd4) $display("FAIL ovf_occ_full: got %0d want 4", occupancy);
    else passed++;
    checks++;
    if (ovf !== 1'b0) $display("FAIL ovf_early: got %b want 0", ovf);
    else passed++;
    en = 1;
    in_data = beat_of(6, 0);
    tick;
    en = 0;
    checks++;
    if (ovf !== 1'b1) $display("FAIL ovf_set: got %b want 1", ovf);
    else passed++;
    checks++;
    if (occupancy !== 3'd4) $display("FAIL ovf_occ_hold: got %0d want 4", occupancy);
    else passed++;
    fire(0, 64'hBEEF, t);
    expect_rec(0, 2, 64'hBEEF, t);
    wait_obs(13);
    tick;
    while (exp.size() > 0) begin
      e = exp.pop_front();
      checks++;
      if (obs.size() == 0) $display("FAIL ovf_beat: got nothing want %b/%h", e.last, e.data);
      else begin
        o = obs.pop_front();
        if ({o.last, o.data} !== {e.last, e.data}) $display("FAIL ovf_beat: got %b/%h want %b/%h", o.last, o.data, e.last, e.data);
        else passed++;
      end
    end
    checks++;
    if (occupancy !== 3'd3) $display("FAIL ovf_occ_after: got %0d want 3", occupancy);
    else passed++;
    clear = 1;
    tick;
    clear = 0;
    checks++;
    if (ovf !== 1'b0) $display("FAIL ovf_clear: got %b want 0", ovf);
    else passed++;
  endtask

  task automatic test_uflow_drop;
    logic [31:0] t;
    beat_t e, o;
    do_reset;
    chan_mask = '1;
    fire(1, 64'h1, t);
    checks++;
    if (uflow !== 1'b1) $display("FAIL uflow_set: got %b want 1", uflow);
    else passed++;
    tick;
    tick;
    tick;
    checks++;
    if (m_valid !== 1'b0 || obs.size() != 0) $display("FAIL uflow_quiet: got m_valid %b beats %0d want 0/0", m_valid, obs.size());
    else passed++;
    clear = 1;
    tick;
    clear = 0;
    checks++;
    if (uflow !== 1'b0) $display("FAIL uflow_clear: got %b want 0", uflow);
    else passed++;
    send_group(0);
    send_group(1);
    m_ready = 0;
    out_valid = '0;
    out_valid[3] = 1;
    out_data[3*OW +: OW] = 64'h33;
    t = tsc;
    tick;
    out_data[3*OW +: OW] = 64'h44;
    tick;
    out_valid = '0;
    expect_rec(3, 0, 64'h33, t);
    checks++;
    if (drop !== 1'b1) $display("FAIL drop_set: got %b want 1", drop);
    else passed++;
    m_ready = 1;
    wait_obs(13);
    tick;
    tick;
    while (exp.size() > 0) begin
      e = exp.pop_front();
      checks++;
      if (obs.size() == 0) $display("FAIL drop_beat: got nothing want %b/%h", e.last, e.data);
      else begin
        o = obs.pop_front();
        if ({o.last, o.data} !== {e.last, e.data}) $display("FAIL drop_beat: got %b/%h want %b/%h", o.last, o.data, e.last, e.data);
        else passed++;
      end
    end
    checks++;
    if (obs.size() != 0) $display("FAIL drop_count: got %0d extra beats want 0", obs.size());
    else passed++;
  endtask

  task automatic test_reset_mid;
    logic [31:0] t;
    beat_t e, o;
    chan_mask = 7'h01;
    m_ready = 1;
    fire(0, 64'h77, t);
    tick;
    tick;
    tick;
    #2 rst_n = 0;
    #1;
    checks++;
    if ({m_valid, m_last} !== 2'b00 || m_data !== '0) $display("FAIL mid_reset_out: got %b%b/%h want 00/0", m_valid, m_last, m_data);
    else passed++;
    checks++;
    if (occupancy !== 3'd0) $display("FAIL mid_reset_occ: got %0d want 0", occupancy);
    else passed++;
    @(negedge clk);
    rst_n = 1;
    tick;
    obs.delete();
    exp.delete();
    for (int n = 0; n < C; n++) seq_m[n] = 0;
    send_group(0);
    fire(0, 64'h88, t);
    expect_rec(0, 0, 64'h88, t);
    wait_obs(13);
    tick;
    while (exp.size() > 0) begin
      e = exp.pop_front();
      checks++;
      if (obs.size() == 0) $display("FAIL mid_beat: got nothing want %b/%h", e.last, e.data);
      else begin
        o = obs.pop_front();
        if ({o.last, o.data} !== {e.last, e.data}) $display("FAIL mid_beat: got %b/%h want %b/%h", o.last, o.data, e.last, e.data);
        else passed++;
      end
    end
    checks++;
    if (obs.size() != 0) $display("FAIL mid_count: got %0d extra beats want 0", obs.size());
    else passed++;
  endtask

  initial begin
    test_reset;
    test_basic;
    test_simultaneous;
    test_backpressure;
    test_overflow;
    test_uflow_drop;
    test_reset_mid;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/pipe_stim_tracker.md
# pipe_stim_tracker

Synthesizable, parametrised stimulus tracker for verifying multi-output pipelines. It records every input beat driven into a pipeline under test into one shared ring buffer. When output channel n of the pipeline asserts valid, it binds that output to the oldest input group channel n has not yet consumed. It then emits a framed record (header, DII input beats, output word) on a valid/ready stream to the software/C-model checker. The per-channel input copies of the previous generation become per-channel read pointers into the shared ring.

## Interface
- PORTS, 4, input words per beat
- DATA_W, 32, width of one input word
- DII, 11, beats per input group (one pipeline initiation)
- CHANNELS, 7, pipeline output channels (≤ 256)
- OUT_W, 64, output word width; must satisfy OUT_W ≤ PORTS*DATA_W and PORTS*DATA_W ≥ 64
- DEPTH, 8, ring capacity in groups (power of 2)

- clk  in  1  single clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- en  in  1  in_data holds a valid input beat this cycle
- in_data  in  PORTS*DATA_W  word p at [p*DATA_W +: DATA_W]
- chan_mask  in  CHANNELS  1 = channel active; 0 = channel ignored, its pointer follows the write pointer
- out_valid  in  CHANNELS  pipeline output n valid
- out_data  in  CHANNELS*OUT_W  channel n at [n*OUT_W +: OUT_W]
- m_valid  out  1  record beat valid
- m_ready  in  1  sink accepts beat
- m_data  out  PORTS*DATA_W  record beat
- m_last  out  1  final beat of record
- clear  in  1  synchronous clear of sticky flags
- ovf / uflow / drop  out  1 each  sticky error flags
- occupancy  out  log2(DEPTH)+1  groups held in ring

## Operation
- Write side: a beat counter (0..DII-1) and a group write pointer wg, log2(DEPTH)+1 bits. When en is high and the ring is not full, the beat is stored at [wg][beat]. When the beat counter wraps, wg increments and the group becomes complete.
- Ring full: (wg − min rg over masked-in channels) == DEPTH. en while full discards the beat, leaves the beat counter unchanged and sets ovf.
- occupancy = wg − min active rg. If no channel is active, occupancy = 0 and groups are freed as soon as they complete.
- Each channel has a read pointer rg[n], a single-entry hold register {out word, 32-bit timestamp}, and a 16-bit sequence counter.
- out_valid[n] with chan_mask[n]=1 behaves as follows:
  - If the hold register is full, the event is lost and drop is set.
  - Else if rg[n] == wg (registered, pre-update value), there is no complete group, the event is ignored and uflow is set.
  - Otherwise out_data and the free-running 32-bit cycle timestamp are latched into the hold register.
- out_valid[n] is ignored when chan_mask[n]=0.
- Emitter FSM:
  - IDLE: round-robin grant among channels with a full hold register. Priority starts at 0 after reset and moves to n+1 after granting n. Go to HDR.
  - HDR: m_data = {zeros, chan[7:0] at [55:48], seq[15:0] at [47:32], timestamp at [31:0]}.
  - BEAT: DII beats, ring[rg[n]][k], k = 0..DII−1.
  - OUT: out word zero-extended; m_last = 1.
  - Each state advances only on m_valid && m_ready. On the OUT handshake: rg[n]++, seq[n]++, hold[n] emptied, back to IDLE.
- Record length is always DII+2 beats.
- clear zeroes ovf/uflow/drop. If an error event occurs in the same cycle as clear, the flag is set (set wins).
- Async reset: all pointers, counters, holds, seq, timestamp, flags = 0; FSM = IDLE; m_valid = 0, m_last = 0, m_data = 0, occupancy = 0, immediately on rst_n low.

## Timing
- Hold register loads at the edge sampling out_valid. With the FSM idle, the HDR beat is on m_valid after the next edge (1-cycle capture-to-header latency).
- Back-to-back records: IDLE costs one cycle between records. Best-case throughput is (DII+3) cycles per record.
- m_data, m_last and the channel grant are stable while m_valid && !m_ready.
- A group completing at edge k can be claimed by out_valid sampled at edge k+1, not at edge k.
- Ring slots freed by rg advance at edge k are writable by en at edge k+1.
- Timestamp wraps modulo 2^32. Sequence wraps modulo 2^16.

## Test plan
- Basic record (defaults): 11 en beats with words 0..43 in lane order, then out_valid[0], out_data=0xDEAD, m_ready=1 -> 13 beats: header chan=0 seq=0, beat k = {4k+3,4k+2,4k+1,4k}, final beat 0xDEAD with m_last; occupancy 1 (other active channels unread).
- Simultaneous channels: one group, out_valid[2] and [5] in the same cycle -> ch2 record, then ch5 record, identical input beats; with chan_mask=0x24, occupancy returns to 0 after both.
- Backpressure: m_ready pseudo-random 50% -> exactly 13 handshakes per record; m_data never changes while stalled.
- Overflow: DEPTH=4, chan_mask=0x01, 5 groups, no out_valid -> ovf=1 at first beat of the 5th group, occupancy=4; then out_valid[0] -> record carries group 0 data; pulse clear -> ovf=0.
- Underflow/drop: out_valid[1] before any group -> uflow=1, no m_valid. After 2 groups, with m_ready=0, out_valid[3] on two consecutive cycles -> drop=1, exactly one record for ch3.
- Reset mid-record: assert rst_n low during BEAT -> m_valid=0 asynchronously, occupancy=0; after release, a new group plus out_valid[0] -> header seq=0.
